celda_iterativa_serial: RTL and testbench

//  Bit-serial, parametrised successor of the single initial cell of the iterative parity array.

---
 rtl/celda_iterativa_serial.sv | 122 ++++++++++++
 tb/tb_celda_iterativa_serial.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/celda_iterativa_serial.sv
// Bit-serial iterative parity cell: applies the X/Y/Z cell recurrence once per clock over a
// latched WIDTH-bit word and reports the final state, last parity flag and count of odd cells.
module celda_iterativa_serial #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [2:0]  INIT_XYZ = 3'b000,
  localparam int unsigned CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] word_in,
  input  logic             msb_first,
  output logic             busy,
  output logic             done,
  output logic             x_out,
  output logic             y_out,
  output logic             z_out,
  output logic             p_out,
  output logic [CW-1:0]    p_count
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic             msb_q;
  logic [IW-1:0]    idx_q;
  logic             x_q, y_q, z_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic             x_out_q, y_out_q, z_out_q, p_out_q;
  logic [CW-1:0]    p_count_q;

  logic [IW-1:0] bit_idx;
  logic          l_bit;
  logic          x_d, y_d, z_d, p_d;
  logic [CW-1:0] cnt_d;

  // Next cell state and parity, all from the pre-update X,Y,Z.
  always_comb begin
    bit_idx = msb_q ? (IW'(WIDTH - 1) - idx_q) : idx_q;
    l_bit   = word_q[bit_idx];
    x_d     = ~x_q & ~z_q & l_bit;
    y_d     = x_q | (y_q & z_q);
    z_d     = ~l_bit;
    p_d     = (x_q & l_bit) | (y_q & ~z_q & l_bit) | (z_q & ~l_bit);
    cnt_d   = cnt_q + CW'(p_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      word_q    <= '0;
      msb_q     <= 1'b0;
      idx_q     <= '0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_out_q   <= 1'b0;
      y_out_q   <= 1'b0;
      z_out_q   <= 1'b0;
      p_out_q   <= 1'b0;
      p_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            word_q            <= word_in;
            msb_q             <= msb_first;
            {x_q, y_q, z_q}   <= INIT_XYZ;
            idx_q             <= '0;
            cnt_q             <= '0;
            busy_q            <= 1'b1;
            state_q           <= StRun;
          end
        end
        StRun: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(WIDTH - 1)) begin
            // Publish results only here so outputs hold across the next run.
            x_out_q   <= x_d;
            y_out_q   <= y_d;
            z_out_q   <= z_d;
            p_out_q   <= p_d;
            p_count_q <= cnt_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_out   = x_out_q;
  assign y_out   = y_out_q;
  assign z_out   = z_out_q;
  assign p_out   = p_out_q;
  assign p_count = p_count_q;

endmodule

// File: tb/tb_celda_iterativa_serial.sv
// Directed bench for celda_iterativa_serial (WIDTH=4, seed 000): table of words with
// hand-computed results plus sequences for back-to-back, reset and ignored-start cases.
module tb_celda_iterativa_serial;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  word_in;
  logic          msb_first;
  logic          busy, done, x_out, y_out, z_out, p_out;
  logic [CW-1:0] p_count;

  int n_tests = 0;
  int n_fail  = 0;

  celda_iterativa_serial #(
    .WIDTH   (W),
    .INIT_XYZ(3'b000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .word_in  (word_in),
    .msb_first(msb_first),
    .busy     (busy),
    .done     (done),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .p_out    (p_out),
    .p_count  (p_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    logic         msb;
    logic [2:0]   xyz;
    logic         p;
    int           cnt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [2:0] xyz, input logic p, input int cnt);
    chk({name, " xyz"}, int'({x_out, y_out, z_out}), int'(xyz));
    chk({name, " p_out"}, int'(p_out), int'(p));
    chk({name, " p_count"}, int'(p_count), cnt);
  endtask

  // lat = posedges after the accepting edge when done is first seen (-1 on timeout).
  // mess: scramble word_in and pulse start while running.
  task automatic run_word(input logic [W-1:0] w, input logic m, input bit mess,
                          output int lat, output int busy_n);
    @(negedge clk);
    word_in   = w;
    msb_first = m;
    start     = 1'b1;
    @(posedge clk);
    lat    = -1;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mess) begin
        word_in = '0;
        start   = (k == 1);
      end
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic run_and_check(input string name, input vec_t v, input bit mess);
    int lat, bn;
    run_word(v.word, v.msb, mess, lat, bn);
    chk({name, " latency"}, lat, W);
    chk({name, " busy cycles"}, bn, W);
    chk_res(name, v.xyz, v.p, v.cnt);
    @(negedge clk);
    chk({name, " done width"}, int'(done), 0);
    chk({name, " idle busy"}, int'(busy), 0);
  endtask

  vec_t vecs[5];
  int   lat, bn, pulses, first_n, last_n;

  initial begin
    vecs[0] = '{word: 4'b1011, msb: 1'b0, xyz: 3'b000, p: 1'b0, cnt: 1};
    vecs[1] = '{word: 4'b1011, msb: 1'b1, xyz: 3'b100, p: 1'b1, cnt: 1};
    vecs[2] = '{word: 4'b0000, msb: 1'b0, xyz: 3'b001, p: 1'b1, cnt: 3};
    vecs[3] = '{word: 4'b1111, msb: 1'b0, xyz: 3'b010, p: 1'b1, cnt: 3};
    vecs[4] = '{word: 4'b0001, msb: 1'b1, xyz: 3'b000, p: 1'b0, cnt: 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    word_in   = '0;
    msb_first = 1'b0;
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk_res("reset", 3'b000, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_and_check($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Outputs keep the previous result while a new run is in progress.
    run_and_check("prev", vecs[1], 1'b0);
    @(negedge clk);
    word_in   = 4'b0000;
    msb_first = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold busy", int'(busy), 1);
    chk_res("hold", 3'b100, 1'b1, 1);
    repeat (4) @(negedge clk);
    chk_res("hold final", 3'b001, 1'b1, 3);

    // start held for 12 edges: accepted at edges 0 and 6 only.
    @(negedge clk);
    word_in   = 4'b1011;
    msb_first = 1'b0;
    start     = 1'b1;
    pulses    = 0;
    first_n   = -1;
    last_n    = -1;
    for (int n = 0; n < 26; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 11) start = 1'b0;
      if (done) begin
        pulses++;
        if (first_n < 0) first_n = n;
        last_n = n;
        chk_res($sformatf("b2b pulse%0d", pulses), 3'b000, 1'b0, 1);
      end
    end
    chk("b2b pulses", pulses, 2);
    chk("b2b spacing", last_n - first_n, W + 2);

    // Reset two cycles into a run.
    @(negedge clk);
    word_in   = 4'b0000;
    msb_first = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk_res("midrst", 3'b000, 1'b0, 0);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 1) rst_n = 1'b1;
      if (done || busy) pulses++;
    end
    chk("midrst no activity", pulses, 0);
    run_and_check("after rst", vecs[0], 1'b0);

    // word_in scrambled and start pulsed during RUN: no effect, no queued run.
    run_and_check("ignore", vecs[0], 1'b1);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("ignore no requeue", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
